rr_interval_meter: RTL and testbench
====================================

// Module: rr_interval_meter
// PURPOSE
//  Downstream of the QRS extremum detector. Measures the R-R interval, in samples
//  (i_ce strobes), between consecutive single-cycle R-peak pulses and emits each
//  interval with a valid/error strobe. Flags intervals outside the physiological range
//  and missing beats (timeout). Feeds the heart-rate and arrhythmia logic.
// PARAMETERS
//  CNT_WIDTH  12   interval counter / o_rr width; must hold RR_MAX
//  RR_MIN     72   shortest legal interval, in samples (matches refractory window)
//  RR_MAX     720  longest legal interval, in samples; also the timeout limit
//  AVG_LOG2   3    log2 of the averaging depth (8 entries); used only with RR_AVG_EN
// PORTS
//  i_clk        in   1          clock
//  i_rst        in   1          synchronous reset, active-high
//  i_ce         in   1          sample strobe; the counter advances only when high
//  i_extremum   in   1          R-peak pulse from the extremum detector
//  o_rr         out  CNT_WIDTH  last interval, or RR_MAX on timeout; holds between strobes
//  o_rr_valid   out  1          1-cycle strobe: a new interval is on o_rr
//  o_rr_err     out  1          1-cycle strobe: interval out of range, or timeout
//  o_rr_avg     out  CNT_WIDTH  mean of the last 2**AVG_LOG2 accepted intervals
//  o_avg_valid  out  1          level: the averaging buffer has been filled once
// BEHAVIOUR
//  - Reset (i_rst high at posedge): all outputs 0, counter 0, avg buffer/sum 0, state IDLE.
//    Reset has priority over every other input in the same cycle.
//  - FSM: IDLE (no reference beat) -> MEASURE on i_extremum; cnt <= 0.
//    MEASURE: cnt += 1 on each i_ce. On i_extremum: iv = cnt + i_ce (same-cycle strobe
//    counts); cnt <= 0; stay in MEASURE.
//    MEASURE -> TIMEOUT when cnt reaches RR_MAX with no beat; cnt saturates and never
//    exceeds RR_MAX. TIMEOUT lasts 1 cycle, then -> IDLE. An i_extremum during the TIMEOUT
//    cycle is taken as a first beat (-> MEASURE, cnt <= 0).
//  - Output latency is 1 clock. In the cycle after an i_extremum in MEASURE: o_rr = iv and
//    o_rr_valid = 1. o_rr_err = 1 in the same cycle if iv < RR_MIN or iv > RR_MAX.
//  - Timeout: in the cycle after cnt reaches RR_MAX: o_rr = RR_MAX, o_rr_err = 1,
//    o_rr_valid = 0.
//  - A first beat (from IDLE) produces no strobe.
//  - i_extremum is sampled every clock, whatever the value of i_ce. Pulse width is 1 cycle.
//    A pulse that stays high is taken on its rising edge only (an internal delayed copy
//    detects the edge).
//  - Strobes are single-cycle. o_rr and o_rr_avg hold their values between strobes.
// CONFIGURATION
//  RR_AVG_EN defined:
//  - Circular buffer of 2**AVG_LOG2 entries. Running sum is CNT_WIDTH+AVG_LOG2 bits.
//  - Only accepted intervals are written (o_rr_valid=1, o_rr_err=0):
//    sum <= sum + iv - oldest; the oldest entry is overwritten; write pointer wraps mod depth.
//  - o_rr_avg = sum >> AVG_LOG2 (truncating), updated 1 clock after o_rr_valid
//    (2 clocks after the beat).
//  - o_avg_valid rises when the 2**AVG_LOG2-th entry is written. It is cleared only by reset.
//  - Rejected intervals and timeouts leave the buffer untouched.
//  RR_AVG_EN undefined:
//  - No buffer is built. o_rr_avg and o_avg_valid are tied to 0.
// TESTING  (defaults; i_ce = 1 every cycle unless stated)
//  1 Reset for 3 cycles -> every output 0. A single pulse after reset -> no strobe.
//  2 Pulses 300 cycles apart -> 1 cycle later o_rr=300, o_rr_valid=1, o_rr_err=0.
//  3 Pulses 50 apart -> o_rr=50, o_rr_valid=1, o_rr_err=1; average unchanged.
//  4 One pulse, then silence -> 720 cycles later o_rr=720, o_rr_err=1, o_rr_valid=0.
//    The next pulse gives no strobe; a pulse 200 cycles after it -> o_rr=200.
//  5 i_ce every 4th cycle, pulses 400 clocks apart -> o_rr=100.
//    Pulse in the same cycle as i_ce -> that strobe is counted.
//  6 RR_AVG_EN: eight intervals of 250 -> o_avg_valid=1, o_rr_avg=250.
//    One more interval of 330 -> o_rr_avg=260. Reset mid-interval -> all 0 and re-sync.

Source files
------------

// File: rtl/rr_interval_meter_if.sv
// Sample-side inputs and interval/average outputs of rr_interval_meter.
// The master drives the strobes; the slave (the meter) drives the results.
interface rr_interval_meter_if #(
    parameter int CNT_WIDTH = 12
);
    logic                 i_ce;
    logic                 i_extremum;
    logic [CNT_WIDTH-1:0] o_rr;
    logic                 o_rr_valid;
    logic                 o_rr_err;
    logic [CNT_WIDTH-1:0] o_rr_avg;
    logic                 o_avg_valid;

    modport master (
        output i_ce,
        output i_extremum,
        input  o_rr,
        input  o_rr_valid,
        input  o_rr_err,
        input  o_rr_avg,
        input  o_avg_valid
    );

    modport slave (
        input  i_ce,
        input  i_extremum,
        output o_rr,
        output o_rr_valid,
        output o_rr_err,
        output o_rr_avg,
        output o_avg_valid
    );
endinterface

// File: rtl/rr_interval_meter.sv
// R-R interval meter: counts i_ce samples between R-peak edges, flags out-of-range
// intervals and missing beats. Optional running average is built when RR_AVG_EN is defined.
module rr_interval_meter #(
    parameter int CNT_WIDTH = 12,
    parameter int RR_MIN    = 72,
    parameter int RR_MAX    = 720,
    parameter int AVG_LOG2  = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    rr_interval_meter_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] RR_MIN_C = CNT_WIDTH'(RR_MIN);
    localparam logic [CNT_WIDTH-1:0] RR_MAX_C = CNT_WIDTH'(RR_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t               r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_rr;
    logic                 r_ext_d;
    logic                 r_rr_valid;
    logic                 r_rr_err;
    logic                 w_beat;
    logic [CNT_WIDTH-1:0] w_iv;
    logic                 w_iv_bad;

    if ((AVG_LOG2 < 1) || (RR_MIN > RR_MAX) || (RR_MAX >= (1 << CNT_WIDTH))) begin : g_bad_params
        $error("rr_interval_meter: inconsistent parameters");
    end

    // A held-high pulse must only count once, hence the rising-edge qualifier.
    assign w_beat   = bus.i_extremum & ~r_ext_d;
    assign w_iv     = r_cnt + {{(CNT_WIDTH-1){1'b0}}, bus.i_ce};
    assign w_iv_bad = (w_iv < RR_MIN_C) || (w_iv > RR_MAX_C);

    // Beat tracking FSM with the registered interval and strobe outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= CNT_ZERO;
            r_ext_d    <= 1'b0;
            r_rr       <= CNT_ZERO;
            r_rr_valid <= 1'b0;
            r_rr_err   <= 1'b0;
        end else begin
            r_ext_d    <= bus.i_extremum;
            r_rr_valid <= 1'b0;
            r_rr_err   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_TIMEOUT: begin
                    r_cnt <= CNT_ZERO;
                    if (w_beat) begin
                        r_state <= ST_MEASURE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_MEASURE: begin
                    if (w_beat) begin
                        r_cnt      <= CNT_ZERO;
                        r_rr       <= w_iv;
                        r_rr_valid <= 1'b1;
                        r_rr_err   <= w_iv_bad;
                    end else if (w_iv >= RR_MAX_C) begin
                        // Missing beat: report the limit and drop the reference.
                        r_state  <= ST_TIMEOUT;
                        r_cnt    <= RR_MAX_C;
                        r_rr     <= RR_MAX_C;
                        r_rr_err <= 1'b1;
                    end else begin
                        r_cnt <= w_iv;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= CNT_ZERO;
                end
            endcase
        end
    end

    assign bus.o_rr       = r_rr;
    assign bus.o_rr_valid = r_rr_valid;
    assign bus.o_rr_err   = r_rr_err;

`ifdef RR_AVG_EN
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = CNT_WIDTH + AVG_LOG2;

    logic [CNT_WIDTH-1:0] r_buf [DEPTH];
    logic [SUM_W-1:0]     r_sum;
    logic [AVG_LOG2-1:0]  r_wptr;
    logic [CNT_WIDTH-1:0] r_rr_avg;
    logic                 r_avg_valid;
    logic                 w_accept;
    logic [SUM_W-1:0]     w_sum_next;

    // The buffer is fed from the registered strobe, so the mean lags o_rr_valid by one clock.
    assign w_accept   = r_rr_valid & ~r_rr_err;
    assign w_sum_next = r_sum + {{AVG_LOG2{1'b0}}, r_rr} - {{AVG_LOG2{1'b0}}, r_buf[r_wptr]};

    // Circular buffer of accepted intervals with a running sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= CNT_ZERO;
            end
            r_sum       <= {SUM_W{1'b0}};
            r_wptr      <= {AVG_LOG2{1'b0}};
            r_rr_avg    <= CNT_ZERO;
            r_avg_valid <= 1'b0;
        end else if (w_accept) begin
            r_buf[r_wptr] <= r_rr;
            r_sum         <= w_sum_next;
            r_wptr        <= r_wptr + AVG_LOG2'(1);
            r_rr_avg      <= w_sum_next[SUM_W-1:AVG_LOG2];
            if (&r_wptr) begin
                r_avg_valid <= 1'b1;
            end
        end
    end

    assign bus.o_rr_avg    = r_rr_avg;
    assign bus.o_avg_valid = r_avg_valid;
`else
    assign bus.o_rr_avg    = CNT_ZERO;
    assign bus.o_avg_valid = 1'b0;
`endif
endmodule

// File: tb/tb_rr_interval_meter.sv
// Self-checking bench for rr_interval_meter: directed vector table, hand sequences for
// timeout/hold/reset/average, and random stimulus against a strobe-count reference model.
module tb_rr_interval_meter;
    localparam int CW       = 12;
    localparam int RR_MIN   = 72;
    localparam int RR_MAX   = 720;
    localparam int AVG_LOG2 = 3;
    localparam int DEPTH    = 8;
`ifdef RR_AVG_EN
    localparam bit AVG_ON = 1'b1;
`else
    localparam bit AVG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    rr_interval_meter_if #(.CNT_WIDTH(CW)) bus ();

    rr_interval_meter #(
        .CNT_WIDTH(CW),
        .RR_MIN   (RR_MIN),
        .RR_MAX   (RR_MAX),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: intervals are differences of a running strobe total.
    int unsigned m_ce_total;
    int unsigned m_ref;
    bit          m_have_ref;
    bit          m_prev_ext;
    int          m_acc_q[$];
    int          m_acc_n;
    int          e_rr;
    int          e_avg;
    bit          e_valid;
    bit          e_err;
    bit          e_avgv;

    typedef struct {
        string name;
        int    gap;
        int    period;
        int    exp_rr;
        bit    exp_err;
    } vec_t;
    vec_t vecs[8];

    function automatic void model_step(bit rst_in, bit ce, bit ext);
        bit          beat;
        int unsigned elapsed;
        int          s;
        if (rst_in) begin
            m_ce_total = 0; m_ref = 0; m_have_ref = 1'b0; m_prev_ext = 1'b0;
            m_acc_q.delete(); m_acc_n = 0;
            e_rr = 0; e_avg = 0; e_valid = 1'b0; e_err = 1'b0; e_avgv = 1'b0;
            return;
        end
        if (AVG_ON && e_valid && !e_err) begin
            m_acc_q.push_back(e_rr);
            if (m_acc_q.size() > DEPTH) void'(m_acc_q.pop_front());
            m_acc_n++;
            s = 0;
            foreach (m_acc_q[i]) s += m_acc_q[i];
            e_avg  = s / DEPTH;
            e_avgv = (m_acc_n >= DEPTH);
        end
        beat       = ext && !m_prev_ext;
        m_prev_ext = ext;
        if (ce) m_ce_total++;
        e_valid = 1'b0;
        e_err   = 1'b0;
        if (m_have_ref) begin
            elapsed = m_ce_total - m_ref;
            if (beat) begin
                e_rr    = int'(elapsed);
                e_valid = 1'b1;
                e_err   = (elapsed < RR_MIN) || (elapsed > RR_MAX);
                m_ref   = m_ce_total;
            end else if (elapsed >= RR_MAX) begin
                e_rr       = RR_MAX;
                e_err      = 1'b1;
                m_have_ref = 1'b0;
            end
        end else if (beat) begin
            m_have_ref = 1'b1;
            m_ref      = m_ce_total;
        end
    endfunction

    task automatic check_model();
        checks++;
        if (bus.o_rr !== CW'(e_rr) || bus.o_rr_valid !== e_valid || bus.o_rr_err !== e_err ||
            bus.o_rr_avg !== CW'(e_avg) || bus.o_avg_valid !== e_avgv) begin
            failures++;
            $display("FAIL model cyc=%0d got rr=%0d v=%b e=%b avg=%0d av=%b want rr=%0d v=%b e=%b avg=%0d av=%b",
                     cyc, bus.o_rr, bus.o_rr_valid, bus.o_rr_err, bus.o_rr_avg, bus.o_avg_valid,
                     e_rr, e_valid, e_err, e_avg, e_avgv);
        end
    endtask

    task automatic check_eq(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (cyc=%0d)", name, got, want, cyc);
        end
    endtask

    task automatic step(input bit r, input bit ce, input bit ext);
        rst            = r;
        bus.i_ce       = ce;
        bus.i_extremum = ext;
        @(posedge clk);
        model_step(r, ce, ext);
        cyc++;
        #1;
        check_model();
    endtask

    // gap-1 quiet clocks then a pulse; i_ce high on every period-th clock.
    task automatic pulse_after(input int gap, input int period);
        for (int k = 1; k < gap; k++) step(1'b0, (cyc % period) == 0, 1'b0);
        step(1'b0, (cyc % period) == 0, 1'b1);
    endtask

    initial begin
        int  countdown;
        int  hold;
        int  mode;
        bit  ce;
        bit  ext;
        bit  r;

        vecs[0] = '{"iv300",    300, 1, 300, 1'b0};
        vecs[1] = '{"iv50",      50, 1,  50, 1'b1};
        vecs[2] = '{"iv_min",    72, 1,  72, 1'b0};
        vecs[3] = '{"iv_min_m1", 71, 1,  71, 1'b1};
        vecs[4] = '{"iv_max",   720, 1, 720, 1'b0};
        vecs[5] = '{"iv2",        2, 1,   2, 1'b1};
        vecs[6] = '{"ce_div4",  400, 4, 100, 1'b0};
        vecs[7] = '{"ce_div2",  200, 2, 100, 1'b0};

        repeat (3) step(1'b1, 1'b1, 1'b0);
        check_eq("reset_rr",    int'(bus.o_rr), 0);
        check_eq("reset_valid", int'(bus.o_rr_valid), 0);
        check_eq("reset_err",   int'(bus.o_rr_err), 0);
        check_eq("reset_avg",   int'(bus.o_rr_avg), 0);
        check_eq("reset_avgv",  int'(bus.o_avg_valid), 0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("first_beat_valid", int'(bus.o_rr_valid), 0);
        check_eq("first_beat_err",   int'(bus.o_rr_err), 0);

        for (int v = 0; v < 8; v++) begin
            pulse_after(vecs[v].gap, vecs[v].period);
            check_eq({vecs[v].name, "_rr"},    int'(bus.o_rr), vecs[v].exp_rr);
            check_eq({vecs[v].name, "_valid"}, int'(bus.o_rr_valid), 1);
            check_eq({vecs[v].name, "_err"},   int'(bus.o_rr_err), int'(vecs[v].exp_err));
        end

        // Timeout, then re-sync with the first beat in the TIMEOUT cycle (t=0) or later (t=1).
        for (int t = 0; t < 2; t++) begin
            pulse_after(100, 1);
            repeat (RR_MAX - 1) step(1'b0, 1'b1, 1'b0);
            check_eq("pre_timeout_err", int'(bus.o_rr_err), 0);
            step(1'b0, 1'b1, 1'b0);
            check_eq("timeout_rr",    int'(bus.o_rr), RR_MAX);
            check_eq("timeout_err",   int'(bus.o_rr_err), 1);
            check_eq("timeout_valid", int'(bus.o_rr_valid), 0);
            repeat (t * 5) step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b1);
            check_eq("post_timeout_valid", int'(bus.o_rr_valid), 0);
            pulse_after(200, 1);
            check_eq("post_timeout_rr",    int'(bus.o_rr), 200);
            check_eq("post_timeout_valid2", int'(bus.o_rr_valid), 1);
        end

        // A pulse held high is taken once, at its rising edge.
        pulse_after(150, 1);
        repeat (4) step(1'b0, 1'b1, 1'b1);
        check_eq("held_no_retrigger", int'(bus.o_rr_valid), 0);
        pulse_after(100, 1);
        check_eq("held_rr", int'(bus.o_rr), 104);

        // Reset mid-interval wins over a coincident pulse.
        pulse_after(100, 1);
        repeat (50) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check_eq("midrst_rr",    int'(bus.o_rr), 0);
        check_eq("midrst_valid", int'(bus.o_rr_valid), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check_eq("midrst_first_valid", int'(bus.o_rr_valid), 0);
        pulse_after(150, 1);
        check_eq("midrst_resync_rr", int'(bus.o_rr), 150);

        // Averaging: 8 x 250, then 330, then a rejected 50, then reset.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        repeat (7) pulse_after(250, 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("avg7",  int'(bus.o_rr_avg), AVG_ON ? 218 : 0);
        check_eq("avgv7", int'(bus.o_avg_valid), 0);
        pulse_after(249, 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("avg8",  int'(bus.o_rr_avg), AVG_ON ? 250 : 0);
        check_eq("avgv8", int'(bus.o_avg_valid), AVG_ON ? 1 : 0);
        pulse_after(329, 1);
        check_eq("avg_iv330", int'(bus.o_rr), 330);
        step(1'b0, 1'b1, 1'b0);
        check_eq("avg9", int'(bus.o_rr_avg), AVG_ON ? 260 : 0);
        pulse_after(49, 1);
        check_eq("avg_rej_err", int'(bus.o_rr_err), 1);
        step(1'b0, 1'b1, 1'b0);
        check_eq("avg_rej_hold", int'(bus.o_rr_avg), AVG_ON ? 260 : 0);
        repeat (30) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check_eq("avg_rst",  int'(bus.o_rr_avg), 0);
        check_eq("avgv_rst", int'(bus.o_avg_valid), 0);

        // Random stimulus, checked every clock against the model.
        countdown = 10;
        hold      = 0;
        mode      = 0;
        for (int n = 0; n < 15000; n++) begin
            if (n % 1000 == 0) mode = int'($urandom_range(0, 2));
            case (mode)
                0:       ce = 1'b1;
                1:       ce = ($urandom_range(0, 1) == 1);
                default: ce = ($urandom_range(0, 3) == 0);
            endcase
            r = ($urandom_range(0, 2999) == 0);
            if (hold > 0) begin
                ext = 1'b1;
                hold--;
            end else if (countdown == 0) begin
                ext       = 1'b1;
                hold      = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
                countdown = int'($urandom_range(1, 900));
            end else begin
                ext = 1'b0;
                countdown--;
            end
            step(r, ce, ext);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
